// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the FSM state encoding, the vector-select encoding and the vector addresses.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        RUN    = 2'd2,
        BR_FIX = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEL_NMI   = 2'd0,
        SEL_RESET = 2'd1,
        SEL_IRQ   = 2'd2,
        SEL_BRK   = 2'd3
    } vec_sel_e;

    localparam logic [15:0] VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] VEC_RESET = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

    function automatic logic [15:0] vec_base(input vec_sel_e sel);
        case (sel)
            SEL_NMI:   vec_base = VEC_NMI;
            SEL_RESET: vec_base = VEC_RESET;
            default:   vec_base = VEC_IRQ;
        endcase
    endfunction

endpackage

// File: rtl/pc_incrementer.sv
// 16-bit combinational program-counter increment.
// The add wraps modulo 2^16, so FFFF steps to 0000.
module pc_incrementer (
    input  logic [15:0] pc_i,
    output logic [15:0] pc_next_o
);

    assign pc_next_o = pc_i + 16'd1;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: vector fetch, jump, relative branch with page fix-up.
// Address outputs are decoded from registered state only.
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       pc_inc,
    input  logic       load_lo,
    input  logic       jump,
    input  logic       branch,
    input  logic       vec_req,
    input  logic [1:0] vec_sel,
    output logic [7:0] addr_low,
    output logic [7:0] addr_high,
    output logic       busy,
    output logic       vec_done,
    output logic       page_cross
);

    state_e      state_q;
    vec_sel_e    vec_sel_q;
    logic [15:0] pc_q;
    logic [7:0]  temp_lo_q;
    logic        br_fwd_q;
    logic        vec_done_q;
    logic        page_cross_q;

    logic [15:0] pc_plus1_d;
    logic [8:0]  br_sum_d;
    logic        br_cross_d;
    logic [7:0]  br_hi_d;
    logic [15:0] addr_d;

    pc_incrementer u_inc (
        .pc_i      (pc_q),
        .pc_next_o (pc_plus1_d)
    );

    // A page is crossed when the carry out of the low byte disagrees with the offset sign.
    assign br_sum_d   = {1'b0, pc_q[7:0]} + {1'b0, data_in};
    assign br_cross_d = br_sum_d[8] ^ data_in[7];
    assign br_hi_d    = br_fwd_q ? (pc_q[15:8] + 8'd1) : (pc_q[15:8] - 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= VEC_LO;
            vec_sel_q    <= SEL_RESET;
            pc_q         <= 16'h0000;
            temp_lo_q    <= 8'h00;
            br_fwd_q     <= 1'b0;
            vec_done_q   <= 1'b0;
            page_cross_q <= 1'b0;
        end else begin
            vec_done_q   <= 1'b0;
            page_cross_q <= 1'b0;
            case (state_q)
                VEC_LO: begin
                    temp_lo_q <= data_in;
                    state_q   <= VEC_HI;
                end
                VEC_HI: begin
                    pc_q       <= {data_in, temp_lo_q};
                    vec_done_q <= 1'b1;
                    state_q    <= RUN;
                end
                BR_FIX: begin
                    pc_q[15:8] <= br_hi_d;
                    state_q    <= RUN;
                end
                default: begin
                    if (vec_req) begin
                        vec_sel_q <= vec_sel_e'(vec_sel);
                        state_q   <= VEC_LO;
                    end else if (jump) begin
                        pc_q <= {data_in, temp_lo_q};
                    end else if (branch) begin
                        // The low byte lands now; the high byte is corrected in BR_FIX.
                        pc_q[7:0] <= br_sum_d[7:0];
                        if (br_cross_d) begin
                            br_fwd_q     <= ~data_in[7];
                            page_cross_q <= 1'b1;
                            state_q      <= BR_FIX;
                        end
                    end else if (pc_inc) begin
                        pc_q <= pc_plus1_d;
                    end
                    if (load_lo && !vec_req && !jump) begin
                        temp_lo_q <= data_in;
                    end
                end
            endcase
        end
    end

    always_comb begin
        addr_d = pc_q;
        case (state_q)
            VEC_LO:  addr_d = vec_base(vec_sel_q);
            VEC_HI:  addr_d = vec_base(vec_sel_q) + 16'd1;
            default: addr_d = pc_q;
        endcase
    end

    assign addr_low   = addr_d[7:0];
    assign addr_high  = addr_d[15:8];
    assign busy       = (state_q != RUN);
    assign vec_done   = vec_done_q;
    assign page_cross = page_cross_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared every cycle against an address-level behavioural model.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       pc_inc = 1'b0, load_lo = 1'b0, jump = 1'b0, branch = 1'b0, vec_req = 1'b0;
    logic [1:0] vec_sel = 2'd0;
    logic [7:0] addr_low, addr_high;
    logic       busy, vec_done, page_cross;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .pc_inc     (pc_inc),
        .load_lo    (load_lo),
        .jump       (jump),
        .branch     (branch),
        .vec_req    (vec_req),
        .vec_sel    (vec_sel),
        .addr_low   (addr_low),
        .addr_high  (addr_high),
        .busy       (busy),
        .vec_done   (vec_done),
        .page_cross (page_cross)
    );

    always #5 clk = ~clk;

    // Model: phase 0 = fetching vector low byte, 1 = high byte, 2 = running, 3 = branch fix-up.
    int          m_phase = 0;
    logic [1:0]  m_vsel  = 2'd1;
    logic [15:0] m_pc    = 16'h0000;
    logic [7:0]  m_tmp   = 8'h00;
    logic [15:0] m_fix_target = 16'h0000;
    logic        m_vd = 1'b0, m_pcx = 1'b0;
    logic        m_valid = 1'b0;

    function automatic logic [15:0] m_base(input logic [1:0] s);
        if (s == 2'd0)      return 16'hFFFA;
        else if (s == 2'd1) return 16'hFFFC;
        else                return 16'hFFFE;
    endfunction

    function automatic logic [15:0] m_addr();
        if (m_phase == 0)      return m_base(m_vsel);
        else if (m_phase == 1) return m_base(m_vsel) + 16'd1;
        else                   return m_pc;
    endfunction

    always @(posedge clk) begin
        logic [15:0] target;
        if (rst) begin
            m_phase = 0; m_vsel = 2'd1; m_pc = 16'h0000; m_tmp = 8'h00;
            m_vd = 1'b0; m_pcx = 1'b0; m_valid = 1'b1;
        end else begin
            m_vd = 1'b0;
            m_pcx = 1'b0;
            if (m_phase == 0) begin
                m_tmp = data_in;
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_pc = {data_in, m_tmp};
                m_vd = 1'b1;
                m_phase = 2;
            end else if (m_phase == 3) begin
                m_pc = m_fix_target;
                m_phase = 2;
            end else begin
                if (vec_req) begin
                    m_vsel = vec_sel;
                    m_phase = 0;
                end else if (jump) begin
                    m_pc = {data_in, m_tmp};
                end else if (branch) begin
                    target = m_pc + {{8{data_in[7]}}, data_in};
                    if (target[15:8] == m_pc[15:8]) begin
                        m_pc = target;
                    end else begin
                        m_fix_target = target;
                        m_pc = {m_pc[15:8], target[7:0]};
                        m_pcx = 1'b1;
                        m_phase = 3;
                    end
                end else if (pc_inc) begin
                    m_pc = m_pc + 16'd1;
                end
                if (load_lo && !vec_req && !jump) m_tmp = data_in;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("addr",       {addr_high, addr_low}, m_addr());
            chk("busy",       {15'd0, busy},         {15'd0, m_phase != 2});
            chk("vec_done",   {15'd0, vec_done},     {15'd0, m_vd});
            chk("page_cross", {15'd0, page_cross},   {15'd0, m_pcx});
        end
    end

    task automatic idle();
        pc_inc = 0; load_lo = 0; jump = 0; branch = 0; vec_req = 0; vec_sel = 2'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
        idle();
    endtask

    task automatic set_pc(input logic [15:0] v);
        load_lo = 1; data_in = v[7:0]; tick();
        jump = 1; data_in = v[15:8]; tick();
    endtask

    task automatic boot(input logic [7:0] lo, input logic [7:0] hi);
        rst = 0; data_in = lo; tick();
        data_in = hi; tick();
    endtask

    function automatic logic [15:0] a();
        return {addr_high, addr_low};
    endfunction

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        chk("lit_reset_addr", a(), 16'hFFFC);
        chk("lit_reset_busy", {15'd0, busy}, 16'd1);
        rst = 0; data_in = 8'h34; tick();
        chk("lit_boot_hi", a(), 16'hFFFD);
        data_in = 8'h12; tick();
        chk("lit_boot_pc", a(), 16'h1234);
        chk("lit_boot_done", {15'd0, vec_done}, 16'd1);
        chk("lit_boot_busy", {15'd0, busy}, 16'd0);
        tick();
        chk("lit_done_pulse", {15'd0, vec_done}, 16'd0);

        set_pc(16'hFFFF);
        pc_inc = 1; tick();
        chk("lit_wrap", a(), 16'h0000);
        load_lo = 1; pc_inc = 1; data_in = 8'hAB; tick();
        chk("lit_inc_load", a(), 16'h0001);
        jump = 1; data_in = 8'h56; tick();
        chk("lit_temp_ab", a(), 16'h56AB);

        set_pc(16'h10F0);
        branch = 1; data_in = 8'h05; tick();
        chk("lit_br_same", a(), 16'h10F5);
        chk("lit_br_same_pcx", {15'd0, page_cross}, 16'd0);
        set_pc(16'h10FE);
        branch = 1; data_in = 8'h04; tick();
        chk("lit_br_fix_addr", a(), 16'h1002);
        chk("lit_br_fix_pcx", {15'd0, page_cross}, 16'd1);
        tick();
        chk("lit_br_fwd", a(), 16'h1102);
        set_pc(16'h1003);
        branch = 1; data_in = 8'hFC; tick();
        chk("lit_br_back_fix", a(), 16'h10FF);
        tick();
        chk("lit_br_back", a(), 16'h0FFF);

        set_pc(16'hC000);
        chk("lit_jump", a(), 16'hC000);
        jump = 1; branch = 1; pc_inc = 1; data_in = 8'h20; tick();
        chk("lit_jump_prio", a(), 16'h2000);

        set_pc(16'h4000);
        vec_req = 1; vec_sel = 2'd0; jump = 1; data_in = 8'h99; tick();
        chk("lit_nmi_lo", a(), 16'hFFFA);
        vec_req = 1; vec_sel = 2'd1; jump = 1; pc_inc = 1; data_in = 8'h78; tick();
        chk("lit_nmi_hi", a(), 16'hFFFB);
        branch = 1; data_in = 8'h56; tick();
        chk("lit_nmi_pc", a(), 16'h5678);
        chk("lit_nmi_done", {15'd0, vec_done}, 16'd1);

        vec_req = 1; vec_sel = 2'd2; tick();
        data_in = 8'h11; tick();
        chk("lit_irq_hi", a(), 16'hFFFF);
        rst = 1; tick();
        chk("lit_rst_vechi", a(), 16'hFFFC);
        chk("lit_rst_vechi_vd", {15'd0, vec_done}, 16'd0);
        boot(8'h00, 8'h00);
        set_pc(16'h10FE);
        branch = 1; data_in = 8'h04; tick();
        rst = 1; tick();
        chk("lit_rst_fix", a(), 16'hFFFC);
        chk("lit_rst_fix_pcx", {15'd0, page_cross}, 16'd0);
        boot(8'h00, 8'h10);
        chk("lit_reboot", a(), 16'h1000);

        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            data_in = 8'($urandom);
            vec_req = ($urandom_range(0, 15) == 0);
            vec_sel = 2'($urandom);
            jump    = ($urandom_range(0, 7) == 0);
            branch  = ($urandom_range(0, 3) == 0);
            pc_inc  = ($urandom_range(0, 1) == 0);
            load_lo = ($urandom_range(0, 2) == 0) && !branch;
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        rst = 0;
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters: none; vector addresses come from the shared package.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 data_in  input  8  data-bus byte; carries vector bytes, jump bytes and branch offsets.
REQ-005 pc_inc  input  1  advance PC by one.
REQ-006 load_lo  input  1  latch data_in into the internal low-byte temp register.
REQ-007 jump  input  1  PC <= {data_in, temp_lo}.
REQ-008 branch  input  1  PC <= PC + sign-extended data_in.
REQ-009 vec_req  input  1  start an interrupt vector fetch.
REQ-010 vec_sel  input  2  vector select: 0=NMI, 1=RESET, 2=IRQ/BRK, 3=IRQ/BRK.
REQ-011 addr_low, addr_high  output  8 each  current address-bus value.
REQ-012 busy  output  1  high in any state other than RUN.
REQ-013 vec_done  output  1  one-cycle pulse when a vector load completes.
REQ-014 page_cross  output  1  high during the branch fix-up cycle.

Function
REQ-015 States: VEC_LO, VEC_HI, RUN, BR_FIX.
REQ-016 Address output by state:
- VEC_LO: vector base.
- VEC_HI: vector base + 1.
- RUN: PC.
- BR_FIX: {old PC high, new low byte}.
REQ-017 VEC_LO: capture data_in into temp_lo; go to VEC_HI next cycle.
REQ-018 VEC_HI: PC <= {data_in, temp_lo}; go to RUN; vec_done = 1 for that one cycle.
REQ-019 Vector bases: NMI = FFFA, RESET = FFFC, IRQ/BRK = FFFE (vec_sel 2 and 3).
REQ-020 RUN priority, highest first: vec_req, jump, branch, pc_inc, load_lo.
- load_lo can coexist with pc_inc in the same cycle.
- load_lo is ignored when jump is also asserted.
REQ-021 RUN + vec_req: latch vec_sel and go to VEC_LO; PC is held.
REQ-022 Increment: 16-bit add, modulo 2^16; FFFF + 1 = 0000.
REQ-023 Branch, low-byte result: sum = PC[7:0] + data_in (unsigned 9-bit).
REQ-024 Branch, no page cross:
- Page cross occurs when sum[8] != data_in[7].
- With no page cross, PC <= {PC[15:8], sum[7:0]} in one cycle; state stays RUN.
REQ-025 Branch, page cross:
- Store the new low byte; go to BR_FIX.
- Next cycle, PC high <= PC[15:8] +1 (forward) or -1 (backward), modulo 256; return to RUN.
REQ-026 Ignored inputs: all control inputs except rst are ignored in VEC_LO, VEC_HI and BR_FIX; no queuing.
REQ-027 Latency:
- jump, branch and pc_inc results appear on addr outputs the cycle after assertion.
- A vector fetch takes exactly 2 cycles from entering VEC_LO.
REQ-028 Outputs are registered state, or combinational decode of registered state only; there is no combinational path from data_in to addr outputs.

Reset
REQ-029 rst = 1 at a clock edge sets: state = VEC_LO, vector = RESET, PC = 0000, temp_lo = 00, page_cross = 0, vec_done = 0.
REQ-030 With rst held, addr = FFFC and busy = 1; the first data_in capture occurs on the first edge with rst = 0.
REQ-031 rst asserted mid-vector-fetch or in BR_FIX aborts the operation and restarts at REQ-029.

Structure
REQ-032 Shared package contents:
- state enum: VEC_LO, VEC_HI, RUN, BR_FIX;
- vector constants: VEC_NMI = 16'hFFFA, VEC_RESET = 16'hFFFC, VEC_IRQ = 16'hFFFE;
- 2-bit vector-select encoding.
REQ-033 One sub-module, pc_incrementer: a 16-bit combinational +1 with wrap, instantiated once.
REQ-034 Branch add and high-byte fix-up stay inside pc_sequencer.

Verification
REQ-035 Reset boot: rst 2 cycles, data_in 34 in VEC_LO, 12 in VEC_HI -> addr FFFC, FFFD, then 1234; vec_done pulses once; busy low.
REQ-036 Wrap: PC = FFFF, pc_inc -> addr 0000; simultaneous load_lo(AB) + pc_inc -> temp_lo = AB and PC incremented.
REQ-037 Branch:
- PC = 10F0, offset 05 -> 10F5 in 1 cycle, page_cross 0.
- PC = 10FE, offset 04 -> BR_FIX addr 1002 with page_cross 1, then 1102.
- PC = 1003, offset FC (-4) -> BR_FIX addr 10FF, then 0FFF.
REQ-038 Jump: load_lo with data 00, then jump with data C0 -> addr C000; jump + branch + pc_inc together -> only the jump takes effect.
REQ-039 NMI: vec_req (vec_sel 0) with jump asserted at PC = 4000 -> addr FFFA, FFFB; jump ignored; PC = vector contents; inputs ignored while busy.
REQ-040 rst asserted in VEC_HI and in BR_FIX -> next addr FFFC, no vec_done, page_cross 0.
